// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module  : alu_pkg
// Brief   : Opcode and multiply-FSM state encodings shared by the accumulator ALU.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_ADC = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
//------------------------------------------------------------------------------
// Module  : alu_mul_seq
// Brief   : Sequential shift-add multiplier, one partial product per cycle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_last;

    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_last      = (r_state == ST_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_mcand  <= {{WIDTH{1'b0}}, a};
                    r_mplier <= b;
                    r_prod   <= '0;
                    r_cnt    <= '0;
                end
            end else begin
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

    // The final product is offered combinationally so the caller can commit it on the last step edge.
    assign busy = (r_state == ST_RUN);
    assign done = w_last;
    assign p    = w_prod_next;

endmodule

`default_nettype wire

// File: rtl/acc_alu_seq.sv
//------------------------------------------------------------------------------
// Module  : acc_alu_seq
// Brief   : Accumulator ALU with flags, 7 single-cycle ops and a sequential multiply.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module acc_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             c,
    input  logic             r,
    input  logic             en,
    input  logic [2:0]       k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             cf,
    output logic             zf,
    output logic             nf,
    output logic             vf,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0]   r_q;
    logic               r_cf;
    logic               r_zf;
    logic               r_nf;
    logic               r_vf;
    logic               r_done;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_p;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_res_cf;
    logic               w_res_vf;
    logic [WIDTH-1:0]   w_mul_lo;

    assign w_accept = en && !w_mul_busy;
    assign w_is_mul = (k == OP_MUL);
    assign w_mul_lo = w_mul_p[WIDTH-1:0];

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk   (c),
        .rst   (r),
        .start (w_accept && w_is_mul),
        .a     (r_q),
        .b     (d),
        .busy  (w_mul_busy),
        .done  (w_mul_done),
        .p     (w_mul_p)
    );

    // Carry-in participates only for ADC and is the previously registered flag.
    assign w_sum  = {1'b0, r_q} + {1'b0, d} + {{WIDTH{1'b0}}, (k == OP_ADC) ? r_cf : 1'b0};
    assign w_diff = {1'b0, r_q} - {1'b0, d};

    always_comb begin
        w_res    = r_q;
        w_res_cf = 1'b0;
        w_res_vf = 1'b0;
        case (k)
            OP_ADD, OP_ADC: begin
                w_res    = w_sum[WIDTH-1:0];
                w_res_cf = w_sum[WIDTH];
                w_res_vf = (r_q[WIDTH-1] == d[WIDTH-1]) && (w_sum[WIDTH-1] != r_q[WIDTH-1]);
            end
            OP_SUB: begin
                w_res    = w_diff[WIDTH-1:0];
                w_res_cf = w_diff[WIDTH];
                w_res_vf = (r_q[WIDTH-1] != d[WIDTH-1]) && (w_diff[WIDTH-1] != r_q[WIDTH-1]);
            end
            OP_AND: w_res = r_q & d;
            OP_OR:  w_res = r_q | d;
            OP_XOR: w_res = r_q ^ d;
            OP_SHL: begin
                w_res    = {r_q[WIDTH-2:0], 1'b0};
                w_res_cf = r_q[WIDTH-1];
                w_res_vf = r_q[WIDTH-1] ^ r_q[WIDTH-2];
            end
            default: begin
                w_res    = r_q;
                w_res_cf = 1'b0;
                w_res_vf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge c) begin
        if (r) begin
            r_q    <= '0;
            r_cf   <= 1'b0;
            r_zf   <= 1'b0;
            r_nf   <= 1'b0;
            r_vf   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_mul_done) begin
                r_q    <= w_mul_lo;
                r_cf   <= |w_mul_p[2*WIDTH-1:WIDTH];
                r_vf   <= 1'b0;
                r_zf   <= (w_mul_lo == '0);
                r_nf   <= w_mul_lo[WIDTH-1];
                r_done <= 1'b1;
            end else if (w_accept && !w_is_mul) begin
                r_q    <= w_res;
                r_cf   <= w_res_cf;
                r_vf   <= w_res_vf;
                r_zf   <= (w_res == '0);
                r_nf   <= w_res[WIDTH-1];
                r_done <= 1'b1;
            end
        end
    end

    assign q    = r_q;
    assign cf   = r_cf;
    assign zf   = r_zf;
    assign nf   = r_nf;
    assign vf   = r_vf;
    assign busy = w_mul_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_acc_alu_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_acc_alu_seq
// Brief   : Scoreboard bench for acc_alu_seq with hand-computed directed vectors.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_acc_alu_seq;

    logic       c = 1'b0;
    logic       r;
    logic       en;
    logic [2:0] k;
    logic [7:0] d;
    logic [7:0] q;
    logic       cf, zf, nf, vf, busy, done;

    int checks   = 0;
    int failures = 0;

    // Expected result record: {q, cf, zf, nf, vf}
    logic [11:0] sb[$];

    acc_alu_seq #(.WIDTH(8)) dut (
        .c    (c),
        .r    (r),
        .en   (en),
        .k    (k),
        .d    (d),
        .q    (q),
        .cf   (cf),
        .zf   (zf),
        .nf   (nf),
        .vf   (vf),
        .busy (busy),
        .done (done)
    );

    always #5 c = ~c;

    function automatic logic [11:0] ex(input logic [7:0] eq, input logic ecf, input logic ezf,
                                       input logic enf, input logic evf);
        return {eq, ecf, ezf, enf, evf};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge c) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                chk("result", {20'd0, q, cf, zf, nf, vf}, {20'd0, e});
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [7:0] dv, input logic [11:0] e);
        @(negedge c);
        en = 1'b1; k = op; d = dv;
        sb.push_back(e);
        @(negedge c);
        en = 1'b0;
    endtask

    initial begin
        r = 1'b1; en = 1'b1; k = 3'b000; d = 8'h55;
        repeat (2) @(negedge c);
        chk("reset_state", {24'd0, q, cf, zf, nf, vf, busy, done}, 32'd0);
        r = 1'b0; en = 1'b0;

        do_op(3'b100, 8'hF0, ex(8'hF0, 0, 0, 1, 0));   // OR  -> load F0
        do_op(3'b000, 8'h20, ex(8'h10, 1, 0, 0, 0));   // ADD
        do_op(3'b001, 8'h00, ex(8'h11, 0, 0, 0, 0));   // ADC with cf=1
        do_op(3'b011, 8'h00, ex(8'h00, 0, 1, 0, 0));   // AND clear
        do_op(3'b100, 8'h80, ex(8'h80, 0, 0, 1, 0));
        do_op(3'b010, 8'h01, ex(8'h7F, 0, 0, 0, 1));   // SUB signed overflow
        do_op(3'b010, 8'h7F, ex(8'h00, 0, 1, 0, 0));
        do_op(3'b100, 8'hC3, ex(8'hC3, 0, 0, 1, 0));
        do_op(3'b101, 8'hC3, ex(8'h00, 0, 1, 0, 0));   // XOR
        do_op(3'b100, 8'h81, ex(8'h81, 0, 0, 1, 0));
        do_op(3'b110, 8'hFF, ex(8'h02, 1, 0, 0, 1));   // SHL, d ignored
        do_op(3'b010, 8'h03, ex(8'hFF, 1, 0, 1, 0));   // SUB with borrow
        do_op(3'b011, 8'h00, ex(8'h00, 0, 1, 0, 0));
        do_op(3'b100, 8'h10, ex(8'h10, 0, 0, 0, 0));

        // MUL 0x10 * 0x11 = 0x110, with an ADD attempted while busy
        @(negedge c);
        en = 1'b1; k = 3'b111; d = 8'h11;
        sb.push_back(ex(8'h10, 1, 0, 0, 0));
        @(negedge c);
        chk("mul_busy_start", {31'd0, busy}, 32'd1);
        en = 1'b1; k = 3'b000; d = 8'h01;
        for (int i = 1; i <= 7; i++) begin
            @(negedge c);
            chk("mul_busy_run", {31'd0, busy, done}, 32'd2);
            if (i == 4) chk("mul_q_hold", {24'd0, q}, 32'h10);
            if (i == 7) en = 1'b0;
        end
        @(negedge c);
        chk("mul_busy_end", {31'd0, busy}, 32'd0);
        @(negedge c);
        chk("mul_done_once", {23'd0, q, done}, {23'd0, 8'h10, 1'b0});

        // Reset asserted in the 4th RUN cycle of a multiply
        @(negedge c);
        en = 1'b1; k = 3'b111; d = 8'h03;
        @(negedge c);
        en = 1'b0;
        chk("mul2_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge c);
        r = 1'b1;
        @(negedge c);
        chk("mid_mul_reset", {22'd0, q, cf, zf, nf, vf, busy, done}, 32'd0);
        r = 1'b0;
        repeat (12) @(negedge c);
        chk("no_late_result", {23'd0, q, busy}, 32'd0);

        do_op(3'b100, 8'h7F, ex(8'h7F, 0, 0, 0, 0));
        do_op(3'b000, 8'h01, ex(8'h80, 0, 0, 1, 1));   // ADD signed overflow

        repeat (2) @(negedge c);
        chk("scoreboard_drain", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
